// File: rtl/bayes_pkg.sv
// bayes_pkg: shared sizes, likelihood-ROM map and FSM state type for the naive-Bayes inference path.
package bayes_pkg;
    localparam int N_CLASS    = 10;
    localparam int N_ATTR     = 784;
    localparam int DW         = 16;
    localparam int ACC_W      = 26;
    localparam int AW         = 14;
    localparam int PXC0_BASE  = 0;
    localparam int PXC1_BASE  = 7840;
    localparam int PRIOR_BASE = 15680;
    typedef enum logic [2:0] {S_IDLE, S_PRIOR, S_SCAN, S_DRAIN, S_CMP, S_DONE} state_t;
endpackage

// File: rtl/bayes_argmax.sv
// bayes_argmax: registered best-score tracker; strict-greater compare so ties keep the earlier (lower) index.
module bayes_argmax #(
    parameter int ACC_W = bayes_pkg::ACC_W,
    parameter int IW    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             upd,
    input  logic [ACC_W-1:0] score,
    input  logic [IW-1:0]    idx,
    output logic [ACC_W-1:0] best,
    output logic [IW-1:0]    best_idx
);
    logic best_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            best_valid <= 1'b0;
            best       <= '0;
            best_idx   <= '0;
        end else if (clr) begin
            best_valid <= 1'b0;
        end else if (upd && (!best_valid || $signed(score) > $signed(best))) begin
            best_valid <= 1'b1;
            best       <= score;
            best_idx   <= idx;
        end
    end
endmodule

// File: rtl/bayes_infer_ctrl.sv
// bayes_infer_ctrl: naive-Bayes MNIST inference sequencer, sole likelihood-ROM master during a run.
// Define BAYES_PRIOR_EN to read and accumulate a per-class log-prior (PRIOR state) before each scan.
module bayes_infer_ctrl #(
    parameter int N_CLASS = bayes_pkg::N_CLASS,
    parameter int N_ATTR  = bayes_pkg::N_ATTR,
    parameter int DW      = bayes_pkg::DW,
    parameter int ACC_W   = bayes_pkg::ACC_W,
    parameter int AW      = bayes_pkg::AW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [0:N_ATTR-1] test_vector,
    output logic              busy,
    output logic              done,
    output logic [3:0]        result_c,
    output logic [ACC_W-1:0]  best_score,
    output logic              rom_en,
    output logic [AW-1:0]     rom_addr,
    input  logic [DW-1:0]     rom_data
);
    import bayes_pkg::*;

    localparam int A_W = $clog2(N_ATTR);
`ifdef BAYES_PRIOR_EN
    localparam state_t S_FIRST = S_PRIOR;
`else
    localparam state_t S_FIRST = S_SCAN;
`endif

    state_t            state, state_nxt;
    logic [0:N_ATTR-1] vec;
    logic [A_W-1:0]    a;
    logic [3:0]        c;
    logic [ACC_W-1:0]  acc;
    logic              rd_vld;
    logic              accept;
    logic              cmp;

    assign accept = state == S_IDLE && start;
    assign cmp    = state == S_CMP;
    assign busy   = state != S_IDLE && state != S_DONE;
    assign done   = state == S_DONE;

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rom_en    = 1'b0;
        rom_addr  = '0;
        case (state)
            S_IDLE:  state_nxt = start ? S_FIRST : S_IDLE;
            S_PRIOR: begin
                rom_en    = 1'b1;
                rom_addr  = AW'(PRIOR_BASE) + AW'(c);
                state_nxt = S_SCAN;
            end
            S_SCAN: begin
                rom_en    = 1'b1;
                rom_addr  = (vec[a] ? AW'(PXC1_BASE) : AW'(PXC0_BASE)) + AW'(c) * AW'(N_ATTR) + AW'(a);
                state_nxt = (a == A_W'(N_ATTR - 1)) ? S_DRAIN : S_SCAN;
            end
            S_DRAIN: state_nxt = S_CMP;
            S_CMP:   state_nxt = (c == 4'(N_CLASS - 1)) ? S_DONE : S_FIRST;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ROM data lags rom_en by one cycle; rd_vld is that delayed tag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vec    <= '0;
            a      <= '0;
            c      <= '0;
            acc    <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rom_en;
            if (accept) begin
                vec <= test_vector;
                a   <= '0;
                c   <= '0;
                acc <= '0;
            end else if (cmp) begin
                a   <= '0;
                acc <= '0;
                if (c != 4'(N_CLASS - 1))
                    c <= c + 4'd1;
            end else begin
                if (state == S_SCAN)
                    a <= a + A_W'(1);
                if (rd_vld)
                    acc <= acc + {{(ACC_W - DW){rom_data[DW-1]}}, rom_data};
            end
        end
    end

    bayes_argmax #(.ACC_W(ACC_W), .IW(4)) u_argmax (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (accept),
        .upd      (cmp),
        .score    (acc),
        .idx      (c),
        .best     (best_score),
        .best_idx (result_c)
    );
endmodule
